// File: rtl/wave_cacher_pingpong.sv
// wave_cacher_pingpong
// Multi-channel ping-pong waveform cacher. It captures signed PCM samples into
// one bank while the FFT reader randomly accesses the other, frozen, bank.
// Optional level trigger: define CACHER_TRIGGER_EN to build in the ARM state,
// the rising-edge comparator on channel 0 and the auto-trigger timeout.
//
// Ports
//   Clock        system (PLL) clock, rising edge
//   Reset        asynchronous active-low reset
//   SampleIn     CH packed samples, channel k at [k*BW_DATA +: BW_DATA]
//   SampleValid  one-cycle strobe qualifying SampleIn
//   DPRAMAddr    read address into the frozen frame
//   Data         registered read data, one cycle after DPRAMAddr
//   FrameReady   frozen frame valid and not yet acknowledged
//   FrameAck     one-cycle strobe, reader done with the frame
//   Overrun      sticky, a sample was dropped while waiting for FrameAck
//   TrigLevel    signed trigger threshold (unused without the trigger)
module wave_cacher_pingpong #(
  parameter int unsigned BW_ADDR = 11,
  parameter int unsigned BW_DATA = 16,
  parameter int unsigned CH      = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [CH*BW_DATA-1:0] SampleIn,
  input  logic                  SampleValid,
  input  logic [BW_ADDR-1:0]    DPRAMAddr,
  output logic [CH*BW_DATA-1:0] Data,
  output logic                  FrameReady,
  input  logic                  FrameAck,
  output logic                  Overrun,
  input  logic [BW_DATA-1:0]    TrigLevel
);

  localparam int unsigned DEPTH = 1 << BW_ADDR;
  localparam int unsigned W     = CH * BW_DATA;

  typedef enum logic [1:0] {ST_ARM, ST_FILL, ST_WAIT} state_t;

`ifdef CACHER_TRIGGER_EN
  localparam state_t ST_INIT = ST_ARM;
`else
  localparam state_t ST_INIT = ST_FILL;
`endif

  logic [W-1:0]       mem [0:1][0:DEPTH-1];
  state_t             state;
  logic [BW_ADDR-1:0] wr_ptr;
  logic               wr_bank;
  logic               last_c;
  logic               wr_en_c;

  assign last_c = (wr_ptr == BW_ADDR'(DEPTH - 1));

`ifdef CACHER_TRIGGER_EN
  logic signed [BW_DATA-1:0] prev_smp;
  logic [BW_ADDR:0]          tmo_cnt;
  logic                      start_c;

  // Upward crossing on channel 0, or timeout after a full frame of discards
  assign start_c = (state == ST_ARM) && SampleValid &&
                   (($signed(prev_smp) < $signed(TrigLevel) &&
                     $signed(SampleIn[BW_DATA-1:0]) >= $signed(TrigLevel)) ||
                    (tmo_cnt == (BW_ADDR+1)'(DEPTH)));
  assign wr_en_c = ((state == ST_FILL) && SampleValid) || start_c;
`else
  logic unused_trig_c;
  assign unused_trig_c = ^TrigLevel;
  assign wr_en_c       = (state == ST_FILL) && SampleValid;
`endif

  // Capture port; wr_ptr is already 0 when a trigger starts a frame
  always_ff @(posedge Clock) begin
    if (wr_en_c) mem[wr_bank][wr_ptr] <= SampleIn;
  end

  // Read port sees the frozen bank as it stands before any swap on this edge
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) Data <= '0;
    else        Data <= mem[~wr_bank][DPRAMAddr];
  end

  // Frame sequencing, handshake and overrun tracking
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_INIT;
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      FrameReady <= 1'b0;
      Overrun    <= 1'b0;
`ifdef CACHER_TRIGGER_EN
      prev_smp   <= {1'b1, {(BW_DATA-1){1'b0}}};
      tmo_cnt    <= '0;
`endif
    end else begin
      // Reader consumed the frame; a same-edge swap below re-raises FrameReady
      if (FrameAck && FrameReady && (state != ST_WAIT)) begin
        FrameReady <= 1'b0;
        Overrun    <= 1'b0;
      end
`ifdef CACHER_TRIGGER_EN
      if (SampleValid) prev_smp <= SampleIn[BW_DATA-1:0];
`endif
      case (state)
        ST_FILL: begin
          if (SampleValid) begin
            wr_ptr <= wr_ptr + BW_ADDR'(1);
            if (last_c) begin
              if (!FrameReady || FrameAck) begin
                wr_bank    <= ~wr_bank;
                FrameReady <= 1'b1;
                state      <= ST_INIT;
`ifdef CACHER_TRIGGER_EN
                tmo_cnt    <= '0;
`endif
              end else begin
                state <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (FrameAck) begin
            wr_bank <= ~wr_bank;
            wr_ptr  <= '0;
            Overrun <= 1'b0;
            state   <= ST_INIT;
`ifdef CACHER_TRIGGER_EN
            tmo_cnt <= '0;
`endif
          end
          // Drop takes priority over the clear from FrameAck
          if (SampleValid) Overrun <= 1'b1;
        end
`ifdef CACHER_TRIGGER_EN
        ST_ARM: begin
          if (start_c) begin
            wr_ptr  <= BW_ADDR'(1);
            tmo_cnt <= '0;
            state   <= ST_FILL;
          end else if (SampleValid) begin
            tmo_cnt <= tmo_cnt + (BW_ADDR+1)'(1);
          end
        end
`endif
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
